multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl_if.sv | 38 +++
 rtl/multicycle_ctrl.sv | 176 +++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle for multicycle_ctrl.
// master: the controller; slave: the datapath/memory side driving opcode, flags and mem_ready.
interface multicycle_ctrl_if #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                zero_flag;
    logic                carry_flag;
    logic                neg_flag;
    logic                mem_ready;
    logic                mem_rd;
    logic                mem_wr;
    logic                pc_we;
    logic [1:0]          pc_src;
    logic                ext_src;
    logic                alu_src;
    logic                reg_des;
    logic                reg_w1;
    logic                reg_w2;
    logic [1:0]          wb_data;
    logic [2:0]          state;
    logic                illegal;
    logic                instr_done;
    logic [CNT_W-1:0]    retired_cnt;

    modport master (
        input  opcode, zero_flag, carry_flag, neg_flag, mem_ready,
        output mem_rd, mem_wr, pc_we, pc_src, ext_src, alu_src, reg_des,
               reg_w1, reg_w2, wb_data, state, illegal, instr_done, retired_cnt
    );

    modport slave (
        output opcode, zero_flag, carry_flag, neg_flag, mem_ready,
        input  mem_rd, mem_wr, pc_we, pc_src, ext_src, alu_src, reg_des,
               reg_w1, reg_w2, wb_data, state, illegal, instr_done, retired_cnt
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU control FSM (IF/ID/EX/MEM/WB/HALT) with retire counter and sticky illegal trap.
// Define STACK_OPS_EN to add CALL/RET/POP to the decoder.
module multicycle_ctrl #(
    parameter int unsigned OPCODE_W = 6,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   bus
);
    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_EX   = 3'b010,
        S_MEM  = 3'b011,
        S_WB   = 3'b100,
        S_HALT = 3'b111
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b000011;
    localparam logic [5:0] OP_LW   = 6'b000101;
    localparam logic [5:0] OP_SW   = 6'b000111;
    localparam logic [5:0] OP_BLT  = 6'b001001;
    localparam logic [5:0] OP_BEQ  = 6'b001010;
    localparam logic [5:0] OP_BNE  = 6'b001011;
    localparam logic [5:0] OP_JMP  = 6'b001100;
`ifdef STACK_OPS_EN
    localparam logic [5:0] OP_CALL = 6'b001101;
    localparam logic [5:0] OP_RET  = 6'b001110;
    localparam logic [5:0] OP_POP  = 6'b010000;
`endif

    state_t           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;
    logic             id_legal;

    logic       mem_rd, mem_wr, pc_we, ext_src, alu_src, reg_des, reg_w1, reg_w2, done;
    logic [1:0] pc_src, wb_data;

    function automatic logic op_in_table(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_LW, OP_SW, OP_BLT, OP_BEQ, OP_BNE, OP_JMP: return 1'b1;
`ifdef STACK_OPS_EN
            OP_CALL, OP_RET, OP_POP: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    // Legal only when the bits above [5:0] are clear and the low field is decodable.
    assign id_legal = (bus.opcode == OPCODE_W'(bus.opcode[5:0])) && op_in_table(bus.opcode[5:0]);

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IF;
        else       state_q <= state_d;
    end

    // Strobes decode from state and the latched opcode, qualified only by the input owned by that state.
    always_comb begin
        state_d = state_q;
        mem_rd  = 1'b0;
        mem_wr  = 1'b0;
        pc_we   = 1'b0;
        pc_src  = 2'd0;
        ext_src = 1'b0;
        alu_src = 1'b0;
        reg_des = 1'b0;
        reg_w1  = 1'b0;
        reg_w2  = 1'b0;
        wb_data = 2'd0;
        done    = 1'b0;
        if (!reset) begin
            case (state_q)
                S_IF: begin
                    mem_rd = 1'b1;
                    if (bus.mem_ready) begin
                        pc_we   = 1'b1;
                        state_d = S_ID;
                    end
                end
                S_ID: begin
                    if (!id_legal) begin
                        state_d = S_HALT;
                    end else begin
                        case (bus.opcode[5:0])
                            OP_JMP: begin
                                pc_we = 1'b1; pc_src = 2'd2; done = 1'b1; state_d = S_IF;
                            end
`ifdef STACK_OPS_EN
                            OP_CALL: begin
                                pc_we = 1'b1; pc_src = 2'd2; reg_w2 = 1'b1; wb_data = 2'd2;
                                done = 1'b1; state_d = S_IF;
                            end
                            OP_RET:  state_d = S_MEM;
`endif
                            default: state_d = S_EX;
                        endcase
                    end
                end
                S_EX: begin
                    case (op_q)
                        OP_R:    state_d = S_WB;
                        OP_ADDI: begin alu_src = 1'b1; ext_src = 1'b1; state_d = S_WB; end
                        OP_LW, OP_SW: state_d = S_MEM;
`ifdef STACK_OPS_EN
                        OP_POP:  state_d = S_MEM;
`endif
                        OP_BEQ:  begin pc_we = bus.zero_flag;                   pc_src = 2'd1; done = 1'b1; state_d = S_IF; end
                        OP_BNE:  begin pc_we = ~bus.zero_flag;                  pc_src = 2'd1; done = 1'b1; state_d = S_IF; end
                        OP_BLT:  begin pc_we = bus.neg_flag ^ bus.carry_flag;   pc_src = 2'd1; done = 1'b1; state_d = S_IF; end
                        default: state_d = S_IF;
                    endcase
                end
                S_MEM: begin
                    mem_wr = (op_q == OP_SW);
                    mem_rd = (op_q != OP_SW);
                    if (bus.mem_ready) begin
                        case (op_q)
                            OP_SW:   begin done = 1'b1; state_d = S_IF; end
`ifdef STACK_OPS_EN
                            OP_RET:  begin pc_we = 1'b1; pc_src = 2'd3; done = 1'b1; state_d = S_IF; end
`endif
                            default: state_d = S_WB;
                        endcase
                    end
                end
                S_WB: begin
                    reg_w1 = 1'b1;
                    case (op_q)
                        OP_R:    reg_des = 1'b1;
                        OP_LW:   wb_data = 2'd1;
`ifdef STACK_OPS_EN
                        OP_POP:  begin wb_data = 2'd1; reg_w2 = 1'b1; end
`endif
                        default: ;
                    endcase
                    done    = 1'b1;
                    state_d = S_IF;
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_IF;
            endcase
        end
    end

    // Opcode latch, sticky trap and retire counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q      <= 6'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (state_q == S_ID) op_q <= bus.opcode[5:0];
            if (state_q == S_ID && !id_legal) illegal_q <= 1'b1;
            if (done) cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bus.mem_rd      = mem_rd;
    assign bus.mem_wr      = mem_wr;
    assign bus.pc_we       = pc_we;
    assign bus.pc_src      = pc_src;
    assign bus.ext_src     = ext_src;
    assign bus.alu_src     = alu_src;
    assign bus.reg_des     = reg_des;
    assign bus.reg_w1      = reg_w1;
    assign bus.reg_w2      = reg_w2;
    assign bus.wb_data     = wb_data;
    assign bus.state       = state_q;
    assign bus.illegal     = illegal_q;
    assign bus.instr_done  = done;
    assign bus.retired_cnt = cnt_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-cycle output vectors from a table, retire-count scoreboard.
module tb_multicycle_ctrl;
    localparam int unsigned OPW = 6;
    localparam int unsigned CW  = 4;

    localparam logic [2:0] ST_IF = 3'd0, ST_ID = 3'd1, ST_EX = 3'd2, ST_MEM = 3'd3,
                           ST_WB = 3'd4, ST_NONE = 3'd5, ST_HALT = 3'd7;

    typedef struct {
        logic [5:0]  op;
        logic        zf, cf, nf;
        int          lat;
        logic [14:0] seq;      // state of cycle i at [3*i +: 3]
        logic [2:0]  pcw_st;   // state with a non-fetch pc_we
        logic [1:0]  pcw_src;
        logic [2:0]  wbd_st;
        logic [1:0]  wbd;
        logic [2:0]  w2_st;
        logic        rdes, imm, mw;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    multicycle_ctrl_if #(.OPCODE_W(OPW), .CNT_W(CW)) bus ();
    multicycle_ctrl #(.OPCODE_W(OPW), .CNT_W(CW)) dut (.clk(clk), .reset(reset), .bus(bus));

    int          errors = 0;
    int          checks = 0;
    int unsigned exp_cnt = 0;
    int unsigned sb[$];
    vec_t        tbl[12];

    function automatic vec_t mk(input logic [5:0] op, input logic zf, input logic cf, input logic nf,
                                input int lat, input logic [2:0] s0, input logic [2:0] s1,
                                input logic [2:0] s2, input logic [2:0] s3, input logic [2:0] s4,
                                input logic [2:0] pcw_st, input logic [1:0] pcw_src,
                                input logic [2:0] wbd_st, input logic [1:0] wbd, input logic [2:0] w2_st,
                                input logic rdes, input logic imm, input logic mw);
        vec_t v;
        v.op = op; v.zf = zf; v.cf = cf; v.nf = nf; v.lat = lat;
        v.seq = {s4, s3, s2, s1, s0};
        v.pcw_st = pcw_st; v.pcw_src = pcw_src; v.wbd_st = wbd_st; v.wbd = wbd; v.w2_st = w2_st;
        v.rdes = rdes; v.imm = imm; v.mw = mw;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [16:0] outs(input logic mask_src);
        return {bus.state, bus.mem_rd, bus.mem_wr, bus.pc_we, mask_src ? 2'd0 : bus.pc_src,
                bus.ext_src, bus.alu_src, bus.reg_des, bus.reg_w1, bus.reg_w2, bus.wb_data,
                bus.illegal, bus.instr_done};
    endfunction

    // Hold reset two edges, checking the quiet reset state; exits just after the edge that releases it.
    task automatic reset_seq(input string tag);
        reset = 1'b1;
        bus.opcode = '0; bus.zero_flag = 1'b0; bus.carry_flag = 1'b0; bus.neg_flag = 1'b0;
        bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk({tag, " reset outs"}, 32'(outs(1'b0)), 32'h0);
        chk({tag, " reset cnt"}, 32'(bus.retired_cnt), 32'h0);
        chk({tag, " sb drained"}, 32'(sb.size()), 32'h0);
        sb.delete();
        exp_cnt = 0;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Run one instruction from IF; mem_wait = MEM cycles with mem_ready low.
    task automatic exec(input vec_t v, input int mem_wait, input string tag);
        logic [2:0]  exq[$];
        logic [2:0]  st;
        logic [16:0] exp;
        logic        rdy, epcw, retired;
        int          memc;
        for (int i = 0; i < v.lat; i++) begin
            st = v.seq[3*i +: 3];
            if (st == ST_MEM) for (int k = 0; k < mem_wait; k++) exq.push_back(st);
            exq.push_back(st);
        end
        exp_cnt = (exp_cnt + 1) % (32'd1 << CW);
        sb.push_back(exp_cnt);
        memc = 0;
        for (int c = 0; c < exq.size(); c++) begin
            st  = exq[c];
            rdy = !(st == ST_MEM && memc < mem_wait);
            if (st == ST_MEM) memc++;
            bus.opcode     = (st == ST_ID) ? OPW'(v.op) : '1;
            bus.zero_flag  = (st == ST_EX) ? v.zf : ~v.zf;
            bus.carry_flag = (st == ST_EX) ? v.cf : ~v.cf;
            bus.neg_flag   = (st == ST_EX) ? v.nf : ~v.nf;
            bus.mem_ready  = rdy;
            @(negedge clk);
            epcw = (st == ST_IF) || (st == v.pcw_st && (st != ST_MEM || rdy));
            exp  = {st, (st == ST_IF) || (st == ST_MEM && !v.mw), st == ST_MEM && v.mw, epcw,
                    (epcw && st != ST_IF) ? v.pcw_src : 2'd0,
                    st == ST_EX && v.imm, st == ST_EX && v.imm, st == ST_WB && v.rdes, st == ST_WB,
                    st == v.w2_st, (st == v.wbd_st) ? v.wbd : 2'd0, 1'b0, c == exq.size() - 1};
            chk($sformatf("%s cyc%0d outs", tag, c), 32'(outs(!epcw)), 32'(exp));
            retired = bus.instr_done;
            @(posedge clk); #1;
            if (retired) begin
                if (sb.size() == 0) chk({tag, " unexpected retire"}, 32'h1, 32'h0);
                else                chk({tag, " retired_cnt"}, 32'(bus.retired_cnt), sb.pop_front());
            end
        end
    endtask

    // Fetch an illegal opcode, then HALT must hold with the trap set whatever the inputs do.
    task automatic illegal_seq(input logic [5:0] op, input string tag);
        bus.opcode = '1; bus.mem_ready = 1'b1;
        @(posedge clk); #1;
        bus.opcode = OPW'(op);
        @(negedge clk);
        chk({tag, " id outs"}, 32'(outs(1'b0)), {15'h0, ST_ID, 14'h0});
        @(posedge clk); #1;
        for (int c = 0; c < 10; c++) begin
            bus.opcode = OPW'($urandom_range(0, 63));
            bus.mem_ready = 1'($urandom); bus.zero_flag = 1'($urandom);
            bus.carry_flag = 1'($urandom); bus.neg_flag = 1'($urandom);
            @(negedge clk);
            chk($sformatf("%s halt cyc%0d", tag, c), 32'(outs(1'b0)), {15'h0, ST_HALT, 12'h0, 2'b10});
            @(posedge clk); #1;
        end
        reset_seq({tag, " recover"});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = mk(6'b000000, 0,0,0, 4, ST_IF,ST_ID,ST_EX,ST_WB,ST_IF,   ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 1,0,0);
        tbl[1]  = mk(6'b000011, 0,0,0, 4, ST_IF,ST_ID,ST_EX,ST_WB,ST_IF,   ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 0,1,0);
        tbl[2]  = mk(6'b000101, 0,0,0, 5, ST_IF,ST_ID,ST_EX,ST_MEM,ST_WB,  ST_NONE,2'd0, ST_WB,2'd1,   ST_NONE, 0,0,0);
        tbl[3]  = mk(6'b000111, 0,0,0, 4, ST_IF,ST_ID,ST_EX,ST_MEM,ST_IF,  ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 0,0,1);
        tbl[4]  = mk(6'b001010, 1,0,0, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_EX,2'd1,   ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[5]  = mk(6'b001010, 0,0,0, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[6]  = mk(6'b001011, 0,0,0, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_EX,2'd1,   ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[7]  = mk(6'b001011, 1,0,0, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[8]  = mk(6'b001001, 0,0,1, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_EX,2'd1,   ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[9]  = mk(6'b001001, 0,1,1, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_NONE,2'd0, ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[10] = mk(6'b001001, 0,1,0, 3, ST_IF,ST_ID,ST_EX,ST_IF,ST_IF,   ST_EX,2'd1,   ST_NONE,2'd0, ST_NONE, 0,0,0);
        tbl[11] = mk(6'b001100, 0,0,0, 2, ST_IF,ST_ID,ST_IF,ST_IF,ST_IF,   ST_ID,2'd2,   ST_NONE,2'd0, ST_NONE, 0,0,0);

        reset_seq("por");

        // Two passes so the 4-bit retire counter wraps.
        for (int rep = 0; rep < 2; rep++)
            for (int i = 0; i < 12; i++) exec(tbl[i], 0, $sformatf("vec%0d.%0d", i, rep));
        exec(tbl[2], 3, "lw_wait3");

        illegal_seq(6'b111111, "ill3f");

        // Reset lands while SW waits in MEM with mem_ready raised on the same edge.
        bus.mem_ready = 1'b1;
        bus.opcode = '1;
        @(posedge clk); #1;
        bus.opcode = OPW'(6'b000111);
        @(posedge clk); #1;
        bus.opcode = '1;
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("sw mem_wait outs", 32'(outs(1'b1)), {15'h0, ST_MEM, 2'b01, 12'h0});
        @(posedge clk); #1;
        reset = 1'b1;
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("sw reset mem_wr", 32'(bus.mem_wr), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        chk("sw reset state", 32'(bus.state), 32'(ST_IF));
        chk("sw reset mem_wr after", 32'(bus.mem_wr), 32'h0);
        chk("sw reset cnt", 32'(bus.retired_cnt), 32'h0);
        chk("sw reset done", 32'(bus.instr_done), 32'h0);
        reset_seq("post_sw");

`ifdef STACK_OPS_EN
        exec(mk(6'b001110, 0,0,0, 3, ST_IF,ST_ID,ST_MEM,ST_IF,ST_IF, ST_MEM,2'd3, ST_NONE,2'd0, ST_NONE, 0,0,0), 0, "ret");
        exec(mk(6'b001110, 0,0,0, 3, ST_IF,ST_ID,ST_MEM,ST_IF,ST_IF, ST_MEM,2'd3, ST_NONE,2'd0, ST_NONE, 0,0,0), 2, "ret_wait2");
        exec(mk(6'b001101, 0,0,0, 2, ST_IF,ST_ID,ST_IF,ST_IF,ST_IF,  ST_ID,2'd2,  ST_ID,2'd2,   ST_ID,   0,0,0), 0, "call");
        exec(mk(6'b010000, 0,0,0, 5, ST_IF,ST_ID,ST_EX,ST_MEM,ST_WB, ST_NONE,2'd0, ST_WB,2'd1,  ST_WB,   0,0,0), 1, "pop");
`else
        illegal_seq(6'b001110, "ret_off");
        illegal_seq(6'b001101, "call_off");
        illegal_seq(6'b010000, "pop_off");
`endif
        chk("final sb drained", 32'(sb.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
